// File: rtl/mem_access_seq_pkg.sv
// Shared encodings for the sequenced MEM stage: opcodes, FSM states and opcode decode.
package mem_access_seq_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_LW   = 3'd1,
        OP_SW   = 3'd2,
        OP_LM   = 3'd3,
        OP_SM   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SREQ = 2'd1,
        ST_MREQ = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Unused encodings 5-7 behave as a plain pass-through.
    function automatic op_e decode_op(input logic [2:0] raw);
        case (raw)
            3'd1:    return OP_LW;
            3'd2:    return OP_SW;
            3'd3:    return OP_LM;
            3'd4:    return OP_SM;
            default: return OP_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_lowbit_enc.sv
// Priority encoder: index of the lowest set bit of vec_i, plus a non-empty flag.
module lowbit_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/mem_access_seq.sv
// Sequenced MEM stage: LW/SW and multi-register LM/SM over a req/ready memory port,
// stalling EX while an access is in flight.
//
//   state   | meaning
//   IDLE    | waiting for in_valid; capture cycle, stall low
//   SREQ    | single LW/SW request held until mem_ready
//   MREQ    | one LM/SM transfer per accepted request, lowest mask bit first
//   DONE    | instruction finished; out_valid pulses on the following cycle
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [2:0]        op_i,
    input  logic              ra_sel_i,
    input  logic              wd_sel_i,
    input  logic [ADDR_W-1:0] pipe_ra_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [DATA_W-1:0] signal_c_i,
    input  logic [NREGS-1:0]  reg_mask_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [IDX_W-1:0]  rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic              rf_we_o,
    output logic [IDX_W-1:0]  rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              stall_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] ra_inc_o
);

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NREGS-1:0]  mask_q;
    logic [NREGS-1:0]  mask_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] ra_inc_q;

    op_e               op_in;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic [IDX_W-1:0]  idx;
    logic              mask_any;

    assign op_in    = decode_op(op_i);
    assign addr_in  = ra_sel_i ? ADDR_W'(alu_out_i) : pipe_ra_i;
    assign wdata_in = wd_sel_i ? signal_c_i : data_in_i;

    lowbit_enc #(
        .N     (NREGS),
        .IDX_W (IDX_W)
    ) u_lowbit (
        .vec_i (mask_q),
        .idx_o (idx),
        .any_o (mask_any)
    );

    assign mask_d = mask_q & ~(NREGS'(1) << idx);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PASS;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ra_inc_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        op_q     <= op_in;
                        addr_q   <= addr_in;
                        wdata_q  <= wdata_in;
                        mask_q   <= reg_mask_i;
                        ra_inc_q <= pipe_ra_i + ADDR_W'(1);
                        if (op_in != OP_LW) out_data_q <= alu_out_i;
                        case (op_in)
                            OP_PASS:      state_q <= ST_DONE;
                            OP_LW, OP_SW: state_q <= ST_SREQ;
                            default:      state_q <= (reg_mask_i == '0) ? ST_DONE : ST_MREQ;
                        endcase
                    end
                end
                ST_SREQ: begin
                    if (mem_ready_i) begin
                        if (op_q == OP_LW) out_data_q <= mem_rdata_i;
                        state_q <= ST_DONE;
                    end
                end
                ST_MREQ: begin
                    if (mem_ready_i) begin
                        mask_q <= mask_d;
                        addr_q <= addr_q + ADDR_W'(1);
                        if (mask_d == '0) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory and register-file strobes are decoded from the state so reset kills them at once.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rf_raddr_o  = '0;
        rf_we_o     = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        case (state_q)
            ST_SREQ: begin
                mem_req_o  = 1'b1;
                mem_we_o   = (op_q == OP_SW);
                mem_addr_o = addr_q;
                if (op_q == OP_SW) mem_wdata_o = wdata_q;
            end
            ST_MREQ: begin
                mem_req_o  = mask_any;
                mem_addr_o = addr_q;
                if (op_q == OP_SM) begin
                    mem_we_o    = 1'b1;
                    rf_raddr_o  = idx;
                    mem_wdata_o = rf_rdata_i;
                end else if (mem_ready_i && mask_any) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = idx;
                    rf_wdata_o = mem_rdata_i;
                end
            end
            default: ;
        endcase
    end

    assign stall_o     = (state_q != ST_IDLE);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign ra_inc_o    = ra_inc_q;

endmodule
